// File: rtl/cam_fb_writer_if.sv
// ---------------------------------------------------------------------------
// cam_fb_writer_if
//   Bundles the camera-side capture inputs and the frame-buffer write port
//   of cam_fb_writer into one interface.
//
//   Camera side (driven by the pixel source):
//     vsync_in   VSYNC, high during vertical blank
//     href_in    HREF, high during an active line
//     pix_valid  one-cycle strobe, assembled 16-bit pixel present
//     pix_data   assembled RGB565 pixel
//     freeze     level, 1 = keep the current buffer contents
//   Frame-buffer side (driven by cam_fb_writer):
//     wr_en      one-cycle write strobe
//     wr_addr    write address
//     wr_data    write data
//     frame_done one-cycle pulse when a captured frame completes
//     frame_cnt  completed captured frames, wraps 255->0
//     capturing  high while a frame is being captured
//
//   master : pixel source / testbench side
//   slave  : cam_fb_writer side
// ---------------------------------------------------------------------------
interface cam_fb_writer_if #(
  parameter int ADDR_W = 15
);
  logic              vsync_in;
  logic              href_in;
  logic              pix_valid;
  logic [15:0]       pix_data;
  logic              freeze;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [15:0]       wr_data;
  logic              frame_done;
  logic [7:0]        frame_cnt;
  logic              capturing;

  modport master (
    output vsync_in, href_in, pix_valid, pix_data, freeze,
    input  wr_en, wr_addr, wr_data, frame_done, frame_cnt, capturing
  );

  modport slave (
    input  vsync_in, href_in, pix_valid, pix_data, freeze,
    output wr_en, wr_addr, wr_data, frame_done, frame_cnt, capturing
  );
endinterface

// File: rtl/cam_fb_writer.sv
// ---------------------------------------------------------------------------
// cam_fb_writer
//   Capture-side controller that writes a decimated camera stream into a
//   FB_W x FB_H RGB565 frame buffer. Frame and line boundaries come from
//   VSYNC/HREF; incoming pixels are counted per line and only every
//   2**DECIM_SHIFT-th column of every 2**DECIM_SHIFT-th line is written.
//   Whole frames can be skipped with freeze, sampled once per frame.
//
//   Ports:
//     clk    system clock, all bus inputs synchronous to it
//     rst_n  asynchronous active-low reset
//     bus    cam_fb_writer_if.slave (camera inputs, write port, status)
// ---------------------------------------------------------------------------
module cam_fb_writer #(
  parameter int FB_W        = 160,
  parameter int FB_H        = 120,
  parameter int DECIM_SHIFT = 2,
  parameter int ADDR_W      = 15,
  parameter int MIRROR_X    = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  cam_fb_writer_if.slave       bus
);

  typedef enum logic [2:0] {
    S_SYNC,
    S_ARM,
    S_CAPTURE,
    S_SKIP,
    S_DONE
  } state_t;

  localparam logic [9:0] FB_W_L = 10'(FB_W);
  localparam logic [9:0] FB_H_L = 10'(FB_H);
  localparam logic [9:0] DMASK  = 10'((1 << DECIM_SHIFT) - 1);

  state_t            state_q, state_d;
  logic              vsync_q, href_q;
  logic [9:0]        col_q, col_d;
  logic [9:0]        row_q, row_d;
  logic              wr_en_q, wr_en_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [15:0]       wr_data_q, wr_data_d;
  logic [7:0]        frame_cnt_q, frame_cnt_d;

  logic              vsync_rise, vsync_fall, href_fall, pix_accept;
  logic [9:0]        x_raw, y_raw, x_m;
  logic [ADDR_W-1:0] y_a, row_base;
  logic              on_grid, in_frame;

  // Edges compare the live input with the previous-cycle sample, so a
  // pixel strobe arriving together with the HREF drop is still seen as
  // belonging to the line that is ending.
  assign vsync_rise = bus.vsync_in & ~vsync_q;
  assign vsync_fall = ~bus.vsync_in & vsync_q;
  assign href_fall  = ~bus.href_in & href_q;
  assign pix_accept = (state_q == S_CAPTURE) & bus.pix_valid &
                      (bus.href_in | href_fall);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_SYNC;
      vsync_q     <= 1'b0;
      href_q      <= 1'b0;
      col_q       <= '0;
      row_q       <= '0;
      wr_en_q     <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      frame_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      vsync_q     <= bus.vsync_in;
      href_q      <= bus.href_in;
      col_q       <= col_d;
      row_q       <= row_d;
      wr_en_q     <= wr_en_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

  // Frame sequencing. After reset the block waits for a complete blank
  // interval (SYNC -> ARM on the rise) so a partially seen frame is never
  // captured; freeze only matters at the ARM decision.
  always_comb begin
    state_d     = state_q;
    frame_cnt_d = frame_cnt_q;
    case (state_q)
      S_SYNC:    if (vsync_rise) state_d = S_ARM;
      S_ARM:     if (vsync_fall) state_d = bus.freeze ? S_SKIP : S_CAPTURE;
      S_CAPTURE: if (vsync_rise) state_d = S_DONE;
      S_SKIP:    if (vsync_rise) state_d = S_ARM;
      S_DONE: begin
        state_d     = S_ARM;
        frame_cnt_d = frame_cnt_q + 8'd1;
      end
      default:   state_d = S_SYNC;
    endcase
  end

  // Pixel position. The pixel on an HREF-fall cycle is counted with the
  // old column; the line advance then overrides the column to 0. Both
  // counters saturate so an over-long line or frame cannot wrap back onto
  // valid buffer coordinates.
  always_comb begin
    col_d = col_q;
    row_d = row_q;
    if (state_q == S_ARM) begin
      col_d = '0;
      row_d = '0;
    end else if (state_q == S_CAPTURE) begin
      if (pix_accept && (col_q != 10'h3FF)) col_d = col_q + 10'd1;
      if (href_fall) begin
        col_d = '0;
        if (row_q != 10'h3FF) row_d = row_q + 10'd1;
      end
    end
  end

  // Decimation, clipping, mirroring and address generation for the pixel
  // presented this cycle; the result is registered for the write port.
  always_comb begin
    x_raw    = col_q >> DECIM_SHIFT;
    y_raw    = row_q >> DECIM_SHIFT;
    on_grid  = ((col_q & DMASK) == 10'd0) && ((row_q & DMASK) == 10'd0);
    in_frame = (x_raw < FB_W_L) && (y_raw < FB_H_L);
    x_m      = (MIRROR_X != 0) ? (FB_W_L - 10'd1 - x_raw) : x_raw;
    y_a      = ADDR_W'(y_raw);
    // 160 = 128 + 32, so the row base is two shifted copies of y.
    if (FB_W == 160) row_base = (y_a << 7) + (y_a << 5);
    else             row_base = y_a * ADDR_W'(FB_W);
    wr_en_d   = pix_accept && on_grid && in_frame;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    if (wr_en_d) begin
      wr_addr_d = row_base + ADDR_W'(x_m);
      wr_data_d = bus.pix_data;
    end
  end

  assign bus.wr_en      = wr_en_q;
  assign bus.wr_addr    = wr_addr_q;
  assign bus.wr_data    = wr_data_q;
  assign bus.frame_done = (state_q == S_DONE);
  assign bus.frame_cnt  = frame_cnt_q;
  assign bus.capturing  = (state_q == S_CAPTURE);

endmodule

// File: tb/tb_cam_fb_writer.sv
// ---------------------------------------------------------------------------
// tb_cam_fb_writer
//   Directed bench for cam_fb_writer. Two instances share one stimulus:
//   dut0 without horizontal mirror, dut1 with it. A negedge monitor logs
//   every write and frame_done pulse; scenario tasks compare the logs and
//   live outputs against hand-computed values.
// ---------------------------------------------------------------------------
module tb_cam_fb_writer;

  localparam int ADDR_W = 15;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        vsync = 1'b0;
  logic        href = 1'b0;
  logic        pix_valid = 1'b0;
  logic        freeze = 1'b0;
  logic [15:0] pix_data = 16'd0;

  int          errors = 0;
  int          checks = 0;
  int          line_no = 0;
  logic [15:0] data_base = 16'd0;

  cam_fb_writer_if #(.ADDR_W(ADDR_W)) if0 ();
  cam_fb_writer_if #(.ADDR_W(ADDR_W)) if1 ();

  assign if0.vsync_in  = vsync;
  assign if0.href_in   = href;
  assign if0.pix_valid = pix_valid;
  assign if0.pix_data  = pix_data;
  assign if0.freeze    = freeze;
  assign if1.vsync_in  = vsync;
  assign if1.href_in   = href;
  assign if1.pix_valid = pix_valid;
  assign if1.pix_data  = pix_data;
  assign if1.freeze    = freeze;

  cam_fb_writer #(.FB_W(160), .FB_H(120), .DECIM_SHIFT(2), .ADDR_W(ADDR_W), .MIRROR_X(0))
    dut0 (.clk(clk), .rst_n(rst_n), .bus(if0.slave));
  cam_fb_writer #(.FB_W(160), .FB_H(120), .DECIM_SHIFT(2), .ADDR_W(ADDR_W), .MIRROR_X(1))
    dut1 (.clk(clk), .rst_n(rst_n), .bus(if1.slave));

  always #5 clk = ~clk;

  // Write/pulse log, sampled on the falling edge.
  int          wcnt0 = 0, wcnt1 = 0, fd0 = 0, fd1 = 0;
  logic [14:0] a0_q[$], a1_q[$];
  logic [15:0] d0_q[$], d1_q[$];
  logic [15:0] fb0 [0:32767];
  logic [15:0] fb1 [0:32767];

  always @(negedge clk) begin
    if (if0.wr_en === 1'b1) begin
      wcnt0 <= wcnt0 + 1;
      a0_q.push_back(if0.wr_addr);
      d0_q.push_back(if0.wr_data);
      fb0[if0.wr_addr] <= if0.wr_data;
    end
    if (if1.wr_en === 1'b1) begin
      wcnt1 <= wcnt1 + 1;
      a1_q.push_back(if1.wr_addr);
      d1_q.push_back(if1.wr_data);
      fb1[if1.wr_addr] <= if1.wr_data;
    end
    if (if0.frame_done === 1'b1) fd0 <= fd0 + 1;
    if (if1.frame_done === 1'b1) fd1 <= fd1 + 1;
  end

  function automatic logic [14:0] addr0_at(int i);
    return (i >= 0 && i < a0_q.size()) ? a0_q[i] : 15'h7FFF;
  endfunction
  function automatic logic [15:0] data0_at(int i);
    return (i >= 0 && i < d0_q.size()) ? d0_q[i] : 16'hDEAD;
  endfunction
  function automatic logic [14:0] addr1_at(int i);
    return (i >= 0 && i < a1_q.size()) ? a1_q[i] : 15'h7FFF;
  endfunction

  task automatic tick(int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // One camera line; with coincide=1 the last pixel shares its cycle with
  // the HREF drop.
  task automatic drive_line(int npix, bit coincide);
    href = 1'b1;
    tick(2);
    for (int c = 0; c < npix; c++) begin
      pix_valid = 1'b1;
      pix_data  = data_base + 16'(line_no * 640 + c);
      if (coincide && c == npix - 1) href = 1'b0;
      tick(1);
    end
    pix_valid = 1'b0;
    href      = 1'b0;
    tick(3);
    line_no++;
  endtask

  task automatic frame_begin();
    vsync = 1'b1;
    tick(4);
    vsync = 1'b0;
    tick(4);
    line_no = 0;
  endtask

  task automatic frame_end();
    vsync = 1'b1;
    tick(6);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick(3);
    checks++; if (if0.wr_en !== 1'b0) begin errors++; $display("[TB] FAIL reset_wr_en: got %0d expected 0", if0.wr_en); end
    checks++; if (if0.wr_addr !== 15'd0) begin errors++; $display("[TB] FAIL reset_wr_addr: got %0d expected 0", if0.wr_addr); end
    checks++; if (if0.wr_data !== 16'd0) begin errors++; $display("[TB] FAIL reset_wr_data: got %0d expected 0", if0.wr_data); end
    checks++; if (if0.frame_done !== 1'b0) begin errors++; $display("[TB] FAIL reset_frame_done: got %0d expected 0", if0.frame_done); end
    checks++; if (if0.frame_cnt !== 8'd0) begin errors++; $display("[TB] FAIL reset_frame_cnt: got %0d expected 0", if0.frame_cnt); end
    checks++; if (if0.capturing !== 1'b0) begin errors++; $display("[TB] FAIL reset_capturing: got %0d expected 0", if0.capturing); end
    checks++; if ({if1.wr_en, if1.wr_addr, if1.capturing} !== 17'd0) begin errors++; $display("[TB] FAIL reset_dut1: got %0h expected 0", {if1.wr_en, if1.wr_addr, if1.capturing}); end
  endtask

  task automatic test_midframe_release();
    int b0, b1, f0;
    data_base = 16'h1000;
    vsync = 1'b0;
    href  = 1'b1;
    tick(2);
    pix_valid = 1'b1;
    tick(3);
    rst_n = 1'b1;
    tick(3);
    pix_valid = 1'b0;
    href = 1'b0;
    tick(3);
    b0 = wcnt0;
    drive_line(8, 1'b0);
    drive_line(8, 1'b0);
    checks++; if (wcnt0 - b0 !== 0) begin errors++; $display("[TB] FAIL release_no_writes: got %0d expected 0", wcnt0 - b0); end
    checks++; if (if0.capturing !== 1'b0) begin errors++; $display("[TB] FAIL release_capturing: got %0d expected 0", if0.capturing); end
    frame_begin();
    b0 = wcnt0; b1 = wcnt1; f0 = fd0;
    drive_line(8, 1'b0);
    checks++; if (wcnt0 - b0 !== 2) begin errors++; $display("[TB] FAIL first_frame_count: got %0d expected 2", wcnt0 - b0); end
    checks++; if (addr0_at(b0) !== 15'd0) begin errors++; $display("[TB] FAIL first_addr: got %0d expected 0", addr0_at(b0)); end
    checks++; if (data0_at(b0) !== 16'h1000) begin errors++; $display("[TB] FAIL first_data: got %0h expected 1000", data0_at(b0)); end
    checks++; if (addr0_at(b0 + 1) !== 15'd1) begin errors++; $display("[TB] FAIL second_addr: got %0d expected 1", addr0_at(b0 + 1)); end
    checks++; if (data0_at(b0 + 1) !== 16'h1004) begin errors++; $display("[TB] FAIL second_data: got %0h expected 1004", data0_at(b0 + 1)); end
    checks++; if (addr1_at(b1) !== 15'd159) begin errors++; $display("[TB] FAIL first_addr_mirror: got %0d expected 159", addr1_at(b1)); end
    checks++; if (if0.frame_cnt !== 8'd0) begin errors++; $display("[TB] FAIL cnt_during_frame: got %0d expected 0", if0.frame_cnt); end
    checks++; if (if0.capturing !== 1'b1) begin errors++; $display("[TB] FAIL capturing_active: got %0d expected 1", if0.capturing); end
    frame_end();
    checks++; if (fd0 - f0 !== 1) begin errors++; $display("[TB] FAIL frame_done_pulses: got %0d expected 1", fd0 - f0); end
    checks++; if (if0.frame_cnt !== 8'd1) begin errors++; $display("[TB] FAIL frame_cnt_1: got %0d expected 1", if0.frame_cnt); end
    checks++; if (if1.frame_cnt !== 8'd1) begin errors++; $display("[TB] FAIL frame_cnt_1_mirror: got %0d expected 1", if1.frame_cnt); end
    checks++; if (if0.capturing !== 1'b0) begin errors++; $display("[TB] FAIL capturing_after: got %0d expected 0", if0.capturing); end
  endtask

  // Full-height frame: lines 0, 4 and 476 carry 640 pixels, all other
  // lines a single pixel at column 0 (so only every 4th line writes once).
  task automatic test_full_frame();
    int b0, b1, f0;
    data_base = 16'h0000;
    frame_begin();
    b0 = wcnt0; b1 = wcnt1; f0 = fd0;
    for (int r = 0; r < 484; r++)
      drive_line((r == 0 || r == 4 || r == 476) ? 640 : 1, 1'b0);
    frame_end();
    checks++; if (wcnt0 - b0 !== 597) begin errors++; $display("[TB] FAIL full_count: got %0d expected 597", wcnt0 - b0); end
    checks++; if (wcnt1 - b1 !== 597) begin errors++; $display("[TB] FAIL full_count_mirror: got %0d expected 597", wcnt1 - b1); end
    checks++; if (addr0_at(b0) !== 15'd0 || data0_at(b0) !== 16'd0) begin errors++; $display("[TB] FAIL full_first: got addr %0d data %0d expected 0/0", addr0_at(b0), data0_at(b0)); end
    checks++; if (fb0[1] !== 16'd4) begin errors++; $display("[TB] FAIL full_addr1: got %0d expected 4", fb0[1]); end
    checks++; if (fb0[160] !== 16'd2560) begin errors++; $display("[TB] FAIL full_addr160: got %0d expected 2560", fb0[160]); end
    checks++; if (fb0[18880] !== 16'd39936) begin errors++; $display("[TB] FAIL full_addr18880: got %0d expected 39936", fb0[18880]); end
    checks++; if (addr0_at(wcnt0 - 1) !== 15'd19199) begin errors++; $display("[TB] FAIL full_last_addr: got %0d expected 19199", addr0_at(wcnt0 - 1)); end
    checks++; if (data0_at(wcnt0 - 1) !== 16'd43132) begin errors++; $display("[TB] FAIL full_last_data: got %0d expected 43132", data0_at(wcnt0 - 1)); end
    checks++; if (addr1_at(b1) !== 15'd159) begin errors++; $display("[TB] FAIL mirror_first: got %0d expected 159", addr1_at(b1)); end
    checks++; if (fb1[0] !== 16'd636) begin errors++; $display("[TB] FAIL mirror_addr0: got %0d expected 636", fb1[0]); end
    checks++; if (fb1[479] !== 16'd5120) begin errors++; $display("[TB] FAIL mirror_addr479: got %0d expected 5120", fb1[479]); end
    checks++; if (addr1_at(wcnt1 - 1) !== 15'd19040) begin errors++; $display("[TB] FAIL mirror_last: got %0d expected 19040", addr1_at(wcnt1 - 1)); end
    checks++; if (fd0 - f0 !== 1) begin errors++; $display("[TB] FAIL full_frame_done: got %0d expected 1", fd0 - f0); end
    checks++; if (if0.frame_cnt !== 8'd2) begin errors++; $display("[TB] FAIL full_frame_cnt: got %0d expected 2", if0.frame_cnt); end
  endtask

  task automatic test_long_line();
    int b0;
    data_base = 16'h2000;
    frame_begin();
    b0 = wcnt0;
    drive_line(700, 1'b0);
    checks++; if (wcnt0 - b0 !== 160) begin errors++; $display("[TB] FAIL long700_count: got %0d expected 160", wcnt0 - b0); end
    checks++; if (addr0_at(wcnt0 - 1) !== 15'd159 || data0_at(wcnt0 - 1) !== 16'h227C) begin errors++; $display("[TB] FAIL long700_last: got addr %0d data %0h expected 159/227c", addr0_at(wcnt0 - 1), data0_at(wcnt0 - 1)); end
    for (int r = 1; r < 4; r++) drive_line(1, 1'b0);
    drive_line(1100, 1'b0);
    checks++; if (wcnt0 - b0 !== 320) begin errors++; $display("[TB] FAIL long1100_count: got %0d expected 320", wcnt0 - b0); end
    checks++; if (addr0_at(b0 + 160) !== 15'd160 || data0_at(b0 + 160) !== 16'h2A00) begin errors++; $display("[TB] FAIL long_row4_first: got addr %0d data %0h expected 160/2a00", addr0_at(b0 + 160), data0_at(b0 + 160)); end
    for (int r = 5; r < 8; r++) drive_line(1, 1'b0);
    drive_line(8, 1'b0);
    checks++; if (wcnt0 - b0 !== 322) begin errors++; $display("[TB] FAIL long_row8_count: got %0d expected 322", wcnt0 - b0); end
    checks++; if (addr0_at(b0 + 320) !== 15'd320) begin errors++; $display("[TB] FAIL long_row8_first: got %0d expected 320", addr0_at(b0 + 320)); end
    frame_end();
    checks++; if (if0.frame_cnt !== 8'd3) begin errors++; $display("[TB] FAIL long_frame_cnt: got %0d expected 3", if0.frame_cnt); end
  endtask

  task automatic test_freeze();
    int b0, f0;
    data_base = 16'h3000;
    freeze = 1'b1;
    frame_begin();
    b0 = wcnt0; f0 = fd0;
    drive_line(8, 1'b0);
    checks++; if (if0.capturing !== 1'b0) begin errors++; $display("[TB] FAIL freeze_capturing: got %0d expected 0", if0.capturing); end
    freeze = 1'b0;
    for (int r = 1; r < 5; r++) drive_line(8, 1'b0);
    frame_end();
    checks++; if (wcnt0 - b0 !== 0) begin errors++; $display("[TB] FAIL freeze_writes: got %0d expected 0", wcnt0 - b0); end
    checks++; if (fd0 - f0 !== 0) begin errors++; $display("[TB] FAIL freeze_frame_done: got %0d expected 0", fd0 - f0); end
    checks++; if (if0.frame_cnt !== 8'd3) begin errors++; $display("[TB] FAIL freeze_frame_cnt: got %0d expected 3", if0.frame_cnt); end
    frame_begin();
    b0 = wcnt0;
    freeze = 1'b1;
    drive_line(8, 1'b0);
    checks++; if (wcnt0 - b0 !== 2) begin errors++; $display("[TB] FAIL unfreeze_writes: got %0d expected 2", wcnt0 - b0); end
    checks++; if (if0.capturing !== 1'b1) begin errors++; $display("[TB] FAIL unfreeze_capturing: got %0d expected 1", if0.capturing); end
    freeze = 1'b0;
    frame_end();
    checks++; if (if0.frame_cnt !== 8'd4) begin errors++; $display("[TB] FAIL unfreeze_frame_cnt: got %0d expected 4", if0.frame_cnt); end
  endtask

  task automatic test_coincide();
    int b0;
    data_base = 16'h4000;
    frame_begin();
    b0 = wcnt0;
    drive_line(637, 1'b1);
    checks++; if (wcnt0 - b0 !== 160) begin errors++; $display("[TB] FAIL coincide_count: got %0d expected 160", wcnt0 - b0); end
    checks++; if (addr0_at(wcnt0 - 1) !== 15'd159 || data0_at(wcnt0 - 1) !== 16'h427C) begin errors++; $display("[TB] FAIL coincide_last: got addr %0d data %0h expected 159/427c", addr0_at(wcnt0 - 1), data0_at(wcnt0 - 1)); end
    checks++; if (addr1_at(wcnt1 - 1) !== 15'd0) begin errors++; $display("[TB] FAIL coincide_mirror: got %0d expected 0", addr1_at(wcnt1 - 1)); end
    for (int r = 1; r < 4; r++) drive_line(4, 1'b0);
    checks++; if (wcnt0 - b0 !== 160) begin errors++; $display("[TB] FAIL coincide_rows123: got %0d expected 160", wcnt0 - b0); end
    drive_line(4, 1'b0);
    checks++; if (wcnt0 - b0 !== 161) begin errors++; $display("[TB] FAIL coincide_row4_count: got %0d expected 161", wcnt0 - b0); end
    checks++; if (addr0_at(wcnt0 - 1) !== 15'd160 || data0_at(wcnt0 - 1) !== 16'h4A00) begin errors++; $display("[TB] FAIL coincide_row4: got addr %0d data %0h expected 160/4a00", addr0_at(wcnt0 - 1), data0_at(wcnt0 - 1)); end
    frame_end();
    checks++; if (if0.frame_cnt !== 8'd5) begin errors++; $display("[TB] FAIL coincide_frame_cnt: got %0d expected 5", if0.frame_cnt); end
  endtask

  // Write latency, hold behaviour, and a write still pending when VSYNC rises.
  task automatic test_latency_pending();
    frame_begin();
    href = 1'b1;
    tick(2);
    pix_valid = 1'b1;
    pix_data  = 16'h5000;
    @(negedge clk);
    checks++; if (if0.wr_en !== 1'b0) begin errors++; $display("[TB] FAIL latency_early: got %0d expected 0", if0.wr_en); end
    @(posedge clk);
    #1;
    pix_valid = 1'b0;
    checks++; if (if0.wr_en !== 1'b1 || if0.wr_addr !== 15'd0 || if0.wr_data !== 16'h5000) begin errors++; $display("[TB] FAIL latency_write: got en %0d addr %0d data %0h expected 1/0/5000", if0.wr_en, if0.wr_addr, if0.wr_data); end
    tick(1);
    checks++; if (if0.wr_en !== 1'b0 || if0.wr_addr !== 15'd0 || if0.wr_data !== 16'h5000) begin errors++; $display("[TB] FAIL latency_hold: got en %0d addr %0d data %0h expected 0/0/5000", if0.wr_en, if0.wr_addr, if0.wr_data); end
    for (int c = 1; c < 9; c++) begin
      pix_valid = 1'b1;
      pix_data  = 16'h5000 + 16'(c);
      tick(1);
    end
    pix_valid = 1'b0;
    vsync = 1'b1;
    checks++; if (if0.wr_en !== 1'b1 || if0.wr_addr !== 15'd2 || if0.frame_done !== 1'b0) begin errors++; $display("[TB] FAIL pending_write: got en %0d addr %0d done %0d expected 1/2/0", if0.wr_en, if0.wr_addr, if0.frame_done); end
    tick(1);
    checks++; if (if0.frame_done !== 1'b1 || if0.wr_en !== 1'b0) begin errors++; $display("[TB] FAIL pending_done: got done %0d en %0d expected 1/0", if0.frame_done, if0.wr_en); end
    tick(1);
    checks++; if (if0.frame_done !== 1'b0 || if0.frame_cnt !== 8'd6) begin errors++; $display("[TB] FAIL pending_after: got done %0d cnt %0d expected 0/6", if0.frame_done, if0.frame_cnt); end
    href = 1'b0;
    tick(4);
  endtask

  task automatic test_async_reset();
    int b0;
    data_base = 16'h6000;
    frame_begin();
    href = 1'b1;
    tick(2);
    for (int c = 0; c < 5; c++) begin
      pix_valid = 1'b1;
      pix_data  = 16'h6000 + 16'(c);
      tick(1);
    end
    pix_valid = 1'b0;
    tick(1);
    checks++; if (if0.capturing !== 1'b1 || if0.wr_addr !== 15'd1) begin errors++; $display("[TB] FAIL areset_before: got cap %0d addr %0d expected 1/1", if0.capturing, if0.wr_addr); end
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (if0.wr_addr !== 15'd0 || if0.wr_data !== 16'd0 || if0.wr_en !== 1'b0) begin errors++; $display("[TB] FAIL areset_wr: got en %0d addr %0d data %0h expected 0/0/0", if0.wr_en, if0.wr_addr, if0.wr_data); end
    checks++; if (if0.frame_cnt !== 8'd0 || if0.capturing !== 1'b0 || if0.frame_done !== 1'b0) begin errors++; $display("[TB] FAIL areset_status: got cnt %0d cap %0d done %0d expected 0/0/0", if0.frame_cnt, if0.capturing, if0.frame_done); end
    tick(2);
    rst_n = 1'b1;
    href = 1'b0;
    tick(2);
    b0 = wcnt0;
    drive_line(8, 1'b0);
    drive_line(8, 1'b0);
    checks++; if (wcnt0 - b0 !== 0) begin errors++; $display("[TB] FAIL areset_sync_writes: got %0d expected 0", wcnt0 - b0); end
    frame_begin();
    b0 = wcnt0;
    drive_line(8, 1'b0);
    checks++; if (wcnt0 - b0 !== 2 || addr0_at(b0) !== 15'd0) begin errors++; $display("[TB] FAIL areset_restart: got count %0d addr %0d expected 2/0", wcnt0 - b0, addr0_at(b0)); end
    frame_end();
    checks++; if (if0.frame_cnt !== 8'd1) begin errors++; $display("[TB] FAIL areset_frame_cnt: got %0d expected 1", if0.frame_cnt); end
  endtask

  initial begin
    $display("[TB] cam_fb_writer directed bench start");
    test_reset();
    test_midframe_release();
    test_full_frame();
    test_long_line();
    test_freeze();
    test_coincide();
    test_latency_pending();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/cam_fb_writer.md
Name: cam_fb_writer

Overview:
Capture-side controller that sequences camera pixel writes into the 160x120 RGB565 frame buffer. It tracks frame and line boundaries from VSYNC/HREF, counts pixels, and decimates the 640x480 stream 4:1 in each axis. It generates the buffer write address and write strobe, and gates capture per frame (freeze/snapshot). Sits between the camera byte-pairing logic and the frame-buffer write port, replacing ad-hoc address arithmetic in the top level.

Parameters:
FB_W, 160, frame-buffer width in pixels
FB_H, 120, frame-buffer height in lines
DECIM_SHIFT, 2, log2 decimation factor per axis
ADDR_W, 15, write address width
MIRROR_X, 1, 1 = horizontal mirror (x' = FB_W-1-x)

Ports:
clk  in  1  system clock; all inputs synchronous to it
rst_n  in  1  asynchronous active-low reset
vsync_in  in  1  camera VSYNC, high during vertical blank
href_in  in  1  camera HREF, high during active line
pix_valid  in  1  one-cycle strobe, assembled 16-bit pixel present
pix_data  in  16  assembled RGB565 pixel
freeze  in  1  level; 1 = hold current buffer contents
wr_en  out  1  frame-buffer write strobe
wr_addr  out  ADDR_W  frame-buffer write address
wr_data  out  16  frame-buffer write data
frame_done  out  1  one-cycle pulse when a captured frame completes
frame_cnt  out  8  count of completed captured frames, wraps 255->0
capturing  out  1  high while in CAPTURE state

Behaviour:
- Reset: state SYNC; wr_en=0, wr_addr=0, wr_data=0, frame_done=0, frame_cnt=0, capturing=0; col/row counters 0; edge-detect registers 0.
- Edge detection: vsync and href registered once; rise/fall derived from current vs. previous sample.
- FSM:
  - SYNC: wait for vsync rise -> ARM. Never captures a partial frame after reset.
  - ARM: on vsync fall: if freeze=1 -> SKIP, else -> CAPTURE. Clear row/col.
  - CAPTURE: capturing=1; on vsync rise -> DONE.
  - SKIP: no writes; on vsync rise -> ARM.
  - DONE: one cycle; frame_done=1, frame_cnt+1; -> ARM.
- freeze is sampled only at the ARM->CAPTURE/SKIP decision. A mid-frame change has no effect until the next frame.
- Counters (CAPTURE only):
  - col (10 bit) increments on each pix_valid, saturates at 1023.
  - On href fall: col=0, row+1 (10 bit, saturating).
  - If pix_valid and href fall coincide, the pixel is counted first, then the line advances.
- Decimation: write candidate when col[DECIM_SHIFT-1:0]==0 and row[DECIM_SHIFT-1:0]==0 at the pix_valid cycle.
  - x = col>>DECIM_SHIFT, y = row>>DECIM_SHIFT.
- Clip: no write if x>=FB_W or y>=FB_H.
- Mirror: if MIRROR_X, x' = FB_W-1-x.
- Address: y*FB_W + x'. For FB_W=160, computed as (y<<7)+(y<<5)+x' in ADDR_W bits. Max address 19199.
- Latency: wr_en/wr_addr/wr_data registered, valid exactly 1 cycle after the qualifying pix_valid. wr_en is a one-cycle pulse per write; wr_addr/wr_data hold their last values when wr_en=0.
- pix_valid outside CAPTURE, or while href=0, is ignored.
- vsync rise while a write is pending in the output register: that write still issues. DONE follows in the next cycle.
- Reset asserted mid-frame: all outputs clear immediately (async). After release, the block restarts in SYNC.

Test Plan:
1. Reset released mid-frame (vsync low, href toggling) -> no wr_en until after a full vsync high->low; first write addr 0, frame_cnt stays 0 until that frame ends.
2. Full 640x480 frame, pix_data=row*640+col, MIRROR_X=0 -> exactly 19200 wr_en pulses; first addr 0 with data 0; addr 1 carries data 4; addr 160 carries data 2560; last addr 19199; one frame_done; frame_cnt=1.
3. Same frame, MIRROR_X=1 -> first write (row 0, col 0) at addr 159; pixel col 636 row 0 at addr 0.
4. Line of 700 pix_valid strobes -> writes only for x<160 (cols 0..636); nothing for col>=640; the next line starts at col 0.
5. freeze=1 held across ARM -> full frame produces zero wr_en, no frame_done, capturing=0. freeze dropped mid-frame -> still no writes until the next frame, which captures normally.
6. pix_valid on same cycle as href fall at col 636, row 0 -> write to addr 159 (MIRROR_X=0); the following line's first write is at addr 0 of row 1 (no write, since row 1 is decimated out); row 4's first write is at addr 160.
